// File: rtl/path_executor_pkg.sv
// Shared encodings and defaults for the path executor and its node qualifier.
package path_executor_pkg;

    localparam int unsigned MAX_CMDS_DEF     = 37;
    localparam int unsigned IDX_W_DEF        = 6;
    localparam int unsigned DEBOUNCE_CYC_DEF = 50000;
    localparam int unsigned CMD_W            = 2;

    typedef logic [CMD_W-1:0] cmd_t;

    localparam cmd_t CMD_STRAIGHT = 2'b00;
    localparam cmd_t CMD_LEFT     = 2'b01;
    localparam cmd_t CMD_RIGHT    = 2'b10;
    localparam cmd_t CMD_BACK     = 2'b11;

    localparam logic [1:0] DIR_W = 2'b00;
    localparam logic [1:0] DIR_E = 2'b01;
    localparam logic [1:0] DIR_N = 2'b10;
    localparam logic [1:0] DIR_S = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_READY,
        ST_WAIT_NODE,
        ST_ISSUE,
        ST_DONE
    } state_e;

endpackage

// File: rtl/path_executor_node_qualifier.sv
// Junction qualifier: 2-flop synchroniser, optional debounce (NODE_DEBOUNCE_EN),
// and a single-cycle rising-edge pulse per junction.
module path_executor_node_qualifier
`ifdef NODE_DEBOUNCE_EN
#(
    parameter int unsigned DEBOUNCE_CYC = 50000
)
`endif
(
    input  logic clk_50,
    input  logic rst_n,
    input  logic node_detect,
    output logic node_pulse_c
);

    logic sync1_q;
    logic sync2_q;

    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= node_detect;
            sync2_q <= sync1_q;
        end
    end

`ifdef NODE_DEBOUNCE_EN
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Saturating run-length of the synchronised level; any low sample restarts it.
    always_comb begin
        cnt_d = cnt_q;
        if (!sync2_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_W'(DEBOUNCE_CYC)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires on the sample that completes the qualify window; saturation blocks retriggers.
    assign node_pulse_c = sync2_q && (cnt_q == CNT_W'(DEBOUNCE_CYC - 1));
`else
    logic prev_q;

    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= sync2_q;
        end
    end

    assign node_pulse_c = sync2_q && !prev_q;
`endif

endmodule

// File: rtl/path_executor.sv
// Buffers the planner's turn list and issues one turn per qualified junction.
// Build option: NODE_DEBOUNCE_EN enables junction debounce in the qualifier.
module path_executor
    import path_executor_pkg::*;
#(
    parameter int unsigned MAX_CMDS     = MAX_CMDS_DEF,
    parameter int unsigned IDX_W        = IDX_W_DEF,
    parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
    input  logic             clk_50,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_data,
    input  logic             cmd_last,
    input  logic             start,
    input  logic             node_detect,
    output logic [1:0]       move_cmd,
    output logic             move_valid,
    input  logic             move_ack,
    output logic [IDX_W-1:0] cmd_idx,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    if (IDX_W < $clog2(MAX_CMDS + 1)) begin : g_idx_w_check
        $error("IDX_W too narrow for MAX_CMDS");
    end
    if (DEBOUNCE_CYC == 0) begin : g_debounce_check
        $error("DEBOUNCE_CYC must be at least 1");
    end

    state_e           state_q, state_d;
    logic [IDX_W-1:0] count_q, count_d;
    logic [IDX_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [IDX_W-1:0] rd_ptr_q, rd_ptr_d;
    cmd_t             move_cmd_q, move_cmd_d;
    logic             move_valid_q, move_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;

    cmd_t             buf_q [MAX_CMDS];
    logic             wr_en_c;
    logic [IDX_W-1:0] wr_addr_c;
    logic             beat_c;
    logic             node_pulse_c;

    path_executor_node_qualifier
`ifdef NODE_DEBOUNCE_EN
    #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    )
`endif
    u_node_qualifier (
        .clk_50       (clk_50),
        .rst_n        (rst_n),
        .node_detect  (node_detect),
        .node_pulse_c (node_pulse_c)
    );

    assign cmd_ready = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    assign beat_c    = cmd_valid && cmd_ready;

    // Next-state, buffer write control and registered-output next values.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        move_cmd_d = move_cmd_q;
        ovf_d      = ovf_q;
        wr_en_c    = 1'b0;
        wr_addr_c  = wr_ptr_q;

        unique case (state_q)
            ST_IDLE: begin
                if (beat_c) begin
                    wr_en_c   = 1'b1;
                    wr_addr_c = '0;
                    count_d   = IDX_W'(1);
                    wr_ptr_d  = IDX_W'(1);
                    ovf_d     = 1'b0;
                    state_d   = cmd_last ? ST_READY : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (beat_c) begin
                    // A full buffer still accepts beats so the planner can drain its list.
                    if (count_q == IDX_W'(MAX_CMDS)) begin
                        ovf_d = 1'b1;
                    end else begin
                        wr_en_c  = 1'b1;
                        count_d  = count_q + IDX_W'(1);
                        wr_ptr_d = wr_ptr_q + IDX_W'(1);
                    end
                    if (cmd_last) begin
                        state_d = ST_READY;
                    end
                end
            end
            ST_READY: begin
                if (start) begin
                    rd_ptr_d = '0;
                    state_d  = ST_WAIT_NODE;
                end
            end
            ST_WAIT_NODE: begin
                if (node_pulse_c) begin
                    move_cmd_d = buf_q[rd_ptr_q];
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (move_ack) begin
                    rd_ptr_d = rd_ptr_q + IDX_W'(1);
                    state_d  = (rd_ptr_q == count_q - IDX_W'(1)) ? ST_DONE : ST_WAIT_NODE;
                end
            end
            ST_DONE: begin
                count_d  = '0;
                wr_ptr_d = '0;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        move_valid_d = (state_d == ST_ISSUE);
        busy_d       = (state_d == ST_WAIT_NODE) || (state_d == ST_ISSUE);
        done_d       = (state_d == ST_DONE);
    end

    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            move_cmd_q   <= '0;
            move_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            move_cmd_q   <= move_cmd_d;
            move_valid_q <= move_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            ovf_q        <= ovf_d;
        end
    end

    // Buffer contents carry no reset; only count/pointers define what is valid.
    always_ff @(posedge clk_50) begin
        if (wr_en_c) begin
            buf_q[wr_addr_c] <= cmd_data;
        end
    end

    assign move_cmd   = move_cmd_q;
    assign move_valid = move_valid_q;
    assign cmd_idx    = rd_ptr_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_path_executor.sv
// Self-checking bench for path_executor: table-driven lists, random lists against a queue model,
// and hand-written corner sequences (held junction level, reset mid-turn, ignored start/beats).
module tb_path_executor;

    localparam int unsigned MAXC = 37;
    localparam int unsigned IW   = 6;
    localparam int unsigned DEB  = 8;
`ifdef NODE_DEBOUNCE_EN
    localparam int unsigned NODE_HOLD = DEB + 4;
    localparam bit          LAT_CHECK = 1'b0;
`else
    localparam int unsigned NODE_HOLD = 2;
    localparam bit          LAT_CHECK = 1'b1;
`endif

    logic          clk_50 = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_data;
    logic          cmd_last;
    logic          start;
    logic          node_detect;
    logic [1:0]    move_cmd;
    logic          move_valid;
    logic          move_ack;
    logic [IW-1:0] cmd_idx;
    logic          busy;
    logic          done;
    logic          overflow;

    always #10 clk_50 = ~clk_50;

    path_executor #(
        .MAX_CMDS     (MAXC),
        .IDX_W        (IW),
        .DEBOUNCE_CYC (DEB)
    ) dut (
        .clk_50      (clk_50),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_data    (cmd_data),
        .cmd_last    (cmd_last),
        .start       (start),
        .node_detect (node_detect),
        .move_cmd    (move_cmd),
        .move_valid  (move_valid),
        .move_ack    (move_ack),
        .cmd_idx     (cmd_idx),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow)
    );

    typedef struct {
        int unsigned len;
        logic [79:0] data;
        logic        exp_ovf;
        int unsigned exp_moves;
        int unsigned ack_dly;
    } vec_t;

    vec_t        vecs [6];
    logic [1:0]  exp_q [$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic load_list(input int unsigned len, input logic [79:0] data, input logic exp_ovf);
        chk("ready_before_load", 32'(cmd_ready), 32'd1);
        for (int i = 0; i < int'(len); i++) begin
            cmd_valid = 1'b1;
            cmd_data  = data[2*i +: 2];
            cmd_last  = (i == int'(len) - 1);
            @(negedge clk_50);
        end
        cmd_valid = 1'b0;
        cmd_last  = 1'b0;
        chk("ready_after_load", 32'(cmd_ready), 32'd0);
        chk("busy_after_load", 32'(busy), 32'd0);
        chk("overflow_after_load", 32'(overflow), 32'(exp_ovf));
    endtask

    task automatic start_run();
        start = 1'b1;
        @(negedge clk_50);
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("idx_after_start", 32'(cmd_idx), 32'd0);
        chk("mv_after_start", 32'(move_valid), 32'd0);
    endtask

    // One junction: raise node, wait (bounded) for the turn, check it, ack after ack_dly cycles.
    task automatic issue_one(input logic [1:0] exp_cmd, input int unsigned idx, input int unsigned ack_dly,
                             input bit last, input bit chk_lat, input bit keep_high);
        int unsigned lat = 0;
        node_detect = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk_50);
            if (c == int'(NODE_HOLD) && !keep_high) node_detect = 1'b0;
            if (move_valid) begin
                lat = c;
                break;
            end
        end
        if (!keep_high) node_detect = 1'b0;
        chk("move_valid_rise", 32'(move_valid), 32'd1);
        if (chk_lat) chk("node_latency", lat, 32'd3);
        chk("move_cmd", 32'(move_cmd), 32'(exp_cmd));
        chk("idx_in_issue", 32'(cmd_idx), idx);
        repeat (ack_dly) @(negedge clk_50);
        chk("move_held", {30'd0, move_valid, 1'b0} | 32'(move_cmd), {30'd0, 1'b1, 1'b0} | 32'(exp_cmd));
        move_ack = 1'b1;
        @(negedge clk_50);
        move_ack = 1'b0;
        chk("move_drop", 32'(move_valid), 32'd0);
        chk("idx_after_ack", 32'(cmd_idx), idx + 1);
        if (last) begin
            chk("done_pulse", 32'(done), 32'd1);
            chk("busy_in_done", 32'(busy), 32'd0);
        end else begin
            chk("busy_between", 32'(busy), 32'd1);
            chk("no_early_done", 32'(done), 32'd0);
        end
    endtask

    task automatic run_list(input int unsigned len, input logic [79:0] data, input logic exp_ovf,
                            input logic [1:0] exp [$], input int unsigned ack_dly);
        load_list(len, data, exp_ovf);
        start_run();
        for (int i = 0; i < exp.size(); i++) begin
            issue_one(exp[i], i, ack_dly, i == exp.size() - 1, LAT_CHECK && i == 0, 1'b0);
        end
        @(negedge clk_50);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("busy_end", 32'(busy), 32'd0);
        chk("ready_end", 32'(cmd_ready), 32'd1);
        chk("overflow_held", 32'(overflow), 32'(exp_ovf));
    endtask

    initial begin
        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_data    = 2'b00;
        cmd_last    = 1'b0;
        start       = 1'b0;
        node_detect = 1'b0;
        move_ack    = 1'b0;

        vecs[0] = '{3,  80'h12,                      1'b0, 3,  5};
        vecs[1] = '{1,  80'h3,                       1'b0, 1,  0};
        vecs[2] = '{40, 80'h9C3A_5F0E_D2B7_4186_E1C9, 1'b1, 37, 1};
        vecs[3] = '{4,  80'hE4,                      1'b0, 4,  2};
        vecs[4] = '{37, 80'h1234_5678_9ABC_DEF0_0FED, 1'b0, 37, 0};
        vecs[5] = '{38, 80'hFFFF_0000_A5A5_5A5A_C3C3, 1'b1, 37, 3};

        repeat (3) @(negedge clk_50);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_move_valid", 32'(move_valid), 32'd0);
        chk("rst_move_cmd", 32'(move_cmd), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_cmd_idx", 32'(cmd_idx), 32'd0);
        rst_n = 1'b1;
        @(negedge clk_50);

        // start while IDLE must not launch anything
        start = 1'b1;
        @(negedge clk_50);
        start = 1'b0;
        chk("start_in_idle", 32'(busy), 32'd0);

        for (int v = 0; v < 6; v++) begin
            exp_q = {};
            for (int i = 0; i < int'(vecs[v].exp_moves); i++) exp_q.push_back(vecs[v].data[2*i +: 2]);
            run_list(vecs[v].len, vecs[v].data, vecs[v].exp_ovf, exp_q, vecs[v].ack_dly);
        end

        // Random lists against a queue model: capacity MAXC, extra beats only raise overflow.
        for (int r = 0; r < 6; r++) begin
            int unsigned len;
            logic [79:0] data;
            logic        ovf;
            logic [1:0]  c;
            len   = $urandom_range(40, 1);
            data  = '0;
            ovf   = 1'b0;
            exp_q = {};
            for (int i = 0; i < int'(len); i++) begin
                c = 2'($urandom_range(3, 0));
                data[2*i +: 2] = c;
                if (exp_q.size() < int'(MAXC)) exp_q.push_back(c);
                else ovf = 1'b1;
            end
            run_list(len, data, ovf, exp_q, $urandom_range(6, 0));
        end

        // Held junction level across an ack: one turn per rising edge only.
        begin
            int unsigned rises = 0;
            load_list(2, 80'h7, 1'b0);
            start_run();
            issue_one(2'b11, 0, 2, 1'b0, 1'b0, 1'b1);
            repeat (200) begin
                @(negedge clk_50);
                if (move_valid) rises++;
            end
            chk("held_level_no_retrigger", rises, 32'd0);
            chk("held_level_idx", 32'(cmd_idx), 32'd1);
            node_detect = 1'b0;
            repeat (3) @(negedge clk_50);
            issue_one(2'b01, 1, 3, 1'b1, 1'b0, 1'b0);
            @(negedge clk_50);
            chk("held_level_end_busy", 32'(busy), 32'd0);
        end

        // Reset while a turn is outstanding.
        load_list(3, 80'h12, 1'b0);
        start_run();
        node_detect = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk_50);
            if (move_valid) break;
        end
        node_detect = 1'b0;
        chk("pre_reset_issue", 32'(move_valid), 32'd1);
        rst_n = 1'b0;
        @(negedge clk_50);
        chk("reset_drops_mv", 32'(move_valid), 32'd0);
        chk("reset_ready", 32'(cmd_ready), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_idx", 32'(cmd_idx), 32'd0);
        rst_n = 1'b1;
        @(negedge clk_50);
        exp_q = {2'b10};
        run_list(1, 80'h2, 1'b0, exp_q, 1);

        // start during LOAD, then beats and stray ack during WAIT_NODE are ignored.
        cmd_valid = 1'b1; cmd_data = 2'b01; cmd_last = 1'b0;
        @(negedge clk_50);
        cmd_data = 2'b10; start = 1'b1;
        @(negedge clk_50);
        start = 1'b0; cmd_data = 2'b11; cmd_last = 1'b1;
        @(negedge clk_50);
        cmd_valid = 1'b0; cmd_last = 1'b0;
        chk("start_in_load_ignored", 32'(busy), 32'd0);
        chk("ready_state_no_ready", 32'(cmd_ready), 32'd0);
        start_run();
        chk("wait_node_no_ready", 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b1; cmd_data = 2'b00; cmd_last = 1'b1; move_ack = 1'b1;
        @(negedge clk_50);
        cmd_valid = 1'b0; cmd_last = 1'b0; move_ack = 1'b0;
        chk("stray_ack_idx", 32'(cmd_idx), 32'd0);
        chk("stray_ack_busy", 32'(busy), 32'd1);
        chk("stray_ack_mv", 32'(move_valid), 32'd0);
        issue_one(2'b01, 0, 1, 1'b0, 1'b0, 1'b0);
        issue_one(2'b10, 1, 1, 1'b0, 1'b0, 1'b0);
        issue_one(2'b11, 2, 1, 1'b1, 1'b0, 1'b0);
        @(negedge clk_50);

`ifdef NODE_DEBOUNCE_EN
        // Short glitch must not qualify; a held level longer than the window must.
        begin
            int unsigned rises = 0;
            load_list(1, 80'h1, 1'b0);
            start_run();
            node_detect = 1'b1;
            repeat (5) @(negedge clk_50);
            node_detect = 1'b0;
            repeat (30) begin
                @(negedge clk_50);
                if (move_valid) rises++;
            end
            chk("glitch_rejected", rises, 32'd0);
            node_detect = 1'b1;
            for (int c = 1; c <= 40; c++) begin
                @(negedge clk_50);
                if (c == int'(DEB) + 1) node_detect = 1'b0;
                if (move_valid) break;
            end
            node_detect = 1'b0;
            chk("debounce_fire", 32'(move_valid), 32'd1);
            chk("debounce_cmd", 32'(move_cmd), 32'd1);
            move_ack = 1'b1;
            @(negedge clk_50);
            move_ack = 1'b0;
            chk("debounce_done", 32'(done), 32'd1);
            @(negedge clk_50);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
